alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 178 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Two-requester front end for a single shared ALU. One operation is in
// flight at a time: a request is accepted in IDLE, its registered operands
// drive the ALU for one EXEC cycle, and the captured result is offered in
// RESP until the consumer takes it.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   reqN_valid / reqN_ready    request handshake for requester N (N = 0, 1)
//   reqN_op, reqN_a, reqN_b    opcode and operands of requester N
//   reqN_psr_we                request may update the flag register
//   alu_arg1, alu_arg2, alu_op drive the shared ALU (zero outside EXEC)
//   alu_result, alu_psr        combinational answer from the shared ALU
//   rsp_valid / rsp_ready      response handshake
//   rsp_id, rsp_result         granted requester and its result
//   psr                        architectural flags {C,L,F,Z,N}
//
// Build option:
//   ALU_ARBITER_FIXED_PRIO_EN  when defined, requester 0 always wins a
//                              contended grant; otherwise round-robin.

module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic               req1_valid,
    output logic               req0_ready,
    output logic               req1_ready,
    input  logic [2:0]         req0_op,
    input  logic [2:0]         req1_op,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    input  logic               req0_psr_we,
    input  logic               req1_psr_we,
    output logic [WIDTH-1:0]   alu_arg1,
    output logic [WIDTH-1:0]   alu_arg2,
    output logic [2:0]         alu_op,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic [REGBITS-1:0] alu_psr,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_result,
    output logic [REGBITS-1:0] psr
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               grant_id;
    logic               any_valid;
    logic               accept;
    logic               flag_op;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               psr_we_r;
    logic               id_r;
    logic [WIDTH-1:0]   rsp_result_r;
    logic [REGBITS-1:0] psr_r;

`ifndef ALU_ARBITER_FIXED_PRIO_EN
    logic               last_grant;
`endif

    // Pick the winner among the valid requesters. A lone requester always
    // wins; a contended grant goes either to requester 0 (fixed priority
    // build) or to whoever did not win last time.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
            grant_id = 1'b0;
`else
            grant_id = ~last_grant;
`endif
        end else begin
            grant_id = req1_valid;
        end
    end

    // State register. Reset wins over everything, which drops any response
    // that was still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one EXEC cycle per operation, then wait in RESP
    // until the consumer takes the result.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = EXEC;
            EXEC:                   state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Output logic. Ready and rsp_valid are masked by reset so that nothing
    // is offered or accepted during the reset cycle even though the state
    // register only clears at the edge. The ALU sees the registered
    // operands only during EXEC and zeros otherwise.
    always_comb begin
        req0_ready = (state == IDLE) && !reset && any_valid && !grant_id;
        req1_ready = (state == IDLE) && !reset && grant_id;
        accept     = req0_ready | req1_ready;
        rsp_valid  = (state == RESP) && !reset;
        alu_arg1   = (state == EXEC) ? a_r  : '0;
        alu_arg2   = (state == EXEC) ? b_r  : '0;
        alu_op     = (state == EXEC) ? op_r : 3'b000;
        rsp_id     = id_r;
        rsp_result = rsp_result_r;
        psr        = psr_r;
    end

    assign flag_op = (op_r == OP_ADD) || (op_r == OP_SUB) || (op_r == OP_CMP);

    // Datapath registers. The winning request is latched on accept so the
    // ALU never sees live request inputs; the ALU answer is captured at the
    // end of EXEC, and only flag-producing ops with write enable touch psr.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r         <= 3'b000;
            a_r          <= '0;
            b_r          <= '0;
            psr_we_r     <= 1'b0;
            id_r         <= 1'b0;
            rsp_result_r <= '0;
            psr_r        <= '0;
        end else begin
            if (accept) begin
                op_r     <= grant_id ? req1_op     : req0_op;
                a_r      <= grant_id ? req1_a      : req0_a;
                b_r      <= grant_id ? req1_b      : req0_b;
                psr_we_r <= grant_id ? req1_psr_we : req0_psr_we;
                id_r     <= grant_id;
            end
            if (state == EXEC) begin
                rsp_result_r <= alu_result;
                if (psr_we_r && flag_op) begin
                    psr_r <= alu_psr;
                end
            end
        end
    end

`ifndef ALU_ARBITER_FIXED_PRIO_EN
    // Round-robin history. Starting at 1 means requester 0 wins the first
    // contended grant after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant_id;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Drives alu_arbiter with directed and randomized requests, plays the role of
// the shared ALU, and checks handshakes, ALU drive, responses and flags
// against a transaction-level model. Expected responses go into a queue that
// a separate monitor drains whenever the DUT presents a response.

module tb_alu_arbiter;

    localparam int WIDTH   = 32;
    localparam int REGBITS = 5;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_CMP  = 3'b111;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               req0_valid, req1_valid;
    logic               req0_ready, req1_ready;
    logic [2:0]         req0_op, req1_op;
    logic [WIDTH-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic               req0_psr_we, req1_psr_we;
    logic [WIDTH-1:0]   alu_arg1, alu_arg2;
    logic [2:0]         alu_op;
    logic [WIDTH-1:0]   alu_result;
    logic [REGBITS-1:0] alu_psr;
    logic               rsp_valid, rsp_ready, rsp_id;
    logic [WIDTH-1:0]   rsp_result;
    logic [REGBITS-1:0] psr;

    typedef struct {
        logic               id;
        logic [WIDTH-1:0]   result;
        logic [REGBITS-1:0] psr;
    } rsp_t;

    rsp_t sb_q[$];
    int   tests    = 0;
    int   failures = 0;

    // Model state: whether an operation is outstanding, how many cycles ago
    // it was accepted, the last winner, and committed / pending flags.
    logic               m_busy = 1'b0;
    int                 m_age  = 0;
    logic               m_last = 1'b1;
    logic [2:0]         m_op   = 3'b000;
    logic [WIDTH-1:0]   m_a    = '0;
    logic [WIDTH-1:0]   m_b    = '0;
    logic [REGBITS-1:0] m_psr  = '0;
    logic [REGBITS-1:0] m_psr_pending = '0;

    alu_arbiter #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_psr_we(req0_psr_we), .req1_psr_we(req1_psr_we),
        .alu_arg1(alu_arg1), .alu_arg2(alu_arg2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_psr(alu_psr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .psr(psr)
    );

    always #5 clk = ~clk;

    // Behavioural ALU returning {C,L,F,Z,N, result}.
    function automatic logic [REGBITS+WIDTH-1:0] alu_ref(input logic [2:0] op,
                                                         input logic [WIDTH-1:0] a,
                                                         input logic [WIDTH-1:0] b);
        logic [WIDTH:0]   wide;
        logic [WIDTH-1:0] r;
        logic             c, l, f;
        c = 1'b0; l = 1'b0; f = 1'b0;
        case (op)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[WIDTH-1:0];
                c = wide[WIDTH];
                f = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                r = a - b;
                c = (a < b);
                l = ($signed(a) < $signed(b));
                f = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_PASS: r = a;
            default: r = a << b[4:0];
        endcase
        return {c, l, f, (r == '0), r[WIDTH-1], r};
    endfunction

    assign {alu_psr, alu_result} = alu_ref(alu_op, alu_arg1, alu_arg2);

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] required);
        tests++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    function automatic logic [WIDTH-1:0] pickOperand();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // One clock cycle: drive inputs just after the rising edge, then at the
    // falling edge compare handshakes, ALU drive and flags with the model and
    // advance the model by one cycle.
    task automatic applyStimulus(input logic rst, input logic v0, input logic v1,
                                 input logic [2:0] op0, input logic [2:0] op1,
                                 input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                                 input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                                 input logic we0, input logic we1, input logic rr);
        logic                       win;
        logic                       we;
        logic [REGBITS+WIDTH-1:0]   res;
        rsp_t                       e;
        @(posedge clk);
        #1;
        reset = rst;
        req0_valid = v0; req1_valid = v1;
        req0_op = op0;   req1_op = op1;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        req0_psr_we = we0; req1_psr_we = we1;
        rsp_ready = rr;
        @(negedge clk);
        checkOutput("psr", 64'(psr), 64'(m_psr));
        if (rst) begin
            checkOutput("req0_ready_in_reset", 64'(req0_ready), 64'd0);
            checkOutput("req1_ready_in_reset", 64'(req1_ready), 64'd0);
            checkOutput("rsp_valid_in_reset", 64'(rsp_valid), 64'd0);
            m_busy = 1'b0;
            m_age  = 0;
            m_last = 1'b1;
            m_psr  = '0;
            sb_q.delete();
        end else begin
            checkOutput("rsp_valid", 64'(rsp_valid), 64'(m_busy && m_age >= 2));
            if (m_busy && m_age == 1) begin
                checkOutput("alu_op", 64'(alu_op), 64'(m_op));
                checkOutput("alu_arg1", 64'(alu_arg1), 64'(m_a));
                checkOutput("alu_arg2", 64'(alu_arg2), 64'(m_b));
            end else begin
                checkOutput("alu_op_idle", 64'(alu_op), 64'd0);
                checkOutput("alu_arg1_idle", 64'(alu_arg1), 64'd0);
                checkOutput("alu_arg2_idle", 64'(alu_arg2), 64'd0);
            end
            if (v0 && v1) win = FIXED_PRIO ? 1'b0 : ~m_last;
            else          win = v1;
            checkOutput("req0_ready", 64'(req0_ready), 64'(!m_busy && v0 && !win));
            checkOutput("req1_ready", 64'(req1_ready), 64'(!m_busy && v1 && win));
            if (m_busy) begin
                if (m_age == 1) m_psr = m_psr_pending;
                if (m_age >= 2 && rr) m_busy = 1'b0;
                else                  m_age++;
            end else if (v0 || v1) begin
                m_op = win ? op1 : op0;
                m_a  = win ? a1  : a0;
                m_b  = win ? b1  : b0;
                we   = win ? we1 : we0;
                res  = alu_ref(m_op, m_a, m_b);
                if (we && (m_op == OP_ADD || m_op == OP_SUB || m_op == OP_CMP))
                    m_psr_pending = res[REGBITS+WIDTH-1:WIDTH];
                else
                    m_psr_pending = m_psr;
                e.id     = win;
                e.result = res[WIDTH-1:0];
                e.psr    = m_psr_pending;
                sb_q.push_back(e);
                m_busy = 1'b1;
                m_age  = 1;
                m_last = win;
            end
        end
    endtask

    task automatic idleCycles(input int n, input logic rr);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, OP_ADD, OP_ADD, '0, '0, '0, '0, 1'b0, 1'b0, rr);
    endtask

    // Monitor: whenever a response is on offer it must match the oldest
    // expected entry; the entry is retired on the handshake.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                failures++;
                $display("[TB] FAIL unexpected_rsp: rsp_valid got 1, expected 0");
            end else begin
                checkOutput("rsp_id", 64'(rsp_id), 64'(sb_q[0].id));
                checkOutput("rsp_result", 64'(rsp_result), 64'(sb_q[0].result));
                checkOutput("rsp_psr", 64'(psr), 64'(sb_q[0].psr));
                if (rsp_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 3'b000; req1_op = 3'b000;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_psr_we = 1'b0; req1_psr_we = 1'b0;
        rsp_ready = 1'b0;

        for (int i = 0; i < 2; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, OP_ADD, OP_ADD, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Simple ADD from requester 0.
        applyStimulus(1'b0, 1'b1, 1'b0, OP_ADD, OP_ADD, 32'd5, 32'd7, '0, '0, 1'b1, 1'b0, 1'b1);
        idleCycles(3, 1'b1);

        // Both requesters contending continuously.
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b0, 1'b1, 1'b1, OP_XOR, OP_SUB, 32'(i), 32'd3, 32'd100, 32'(i),
                          1'b0, 1'b0, 1'b1);
        idleCycles(3, 1'b1);

        // Carry-out boundary with and without flag write.
        applyStimulus(1'b0, 1'b0, 1'b1, OP_ADD, OP_ADD, '0, '0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1);
        idleCycles(3, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, OP_ADD, OP_ADD, '0, '0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b1);
        idleCycles(3, 1'b1);

        // Leave psr at C only, then an OR with write enable must not touch it.
        applyStimulus(1'b0, 1'b1, 1'b0, OP_ADD, OP_ADD, 32'hFFFF_FFFF, 32'd2, '0, '0, 1'b1, 1'b0, 1'b1);
        idleCycles(3, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, OP_OR, OP_ADD, 32'h0F0F_0000, 32'h0000_00F0, '0, '0, 1'b1, 1'b0, 1'b1);
        idleCycles(3, 1'b1);

        // Consumer stalls in RESP while both requesters knock.
        applyStimulus(1'b0, 1'b1, 1'b0, OP_SUB, OP_ADD, 32'd3, 32'd9, '0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b1, 1'b1, OP_AND, OP_OR, 32'hAA, 32'h0F, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
        idleCycles(3, 1'b1);

        // Reset while the operation is executing, then a contended grant.
        applyStimulus(1'b0, 1'b1, 1'b0, OP_CMP, OP_ADD, 32'd1, 32'd2, '0, '0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, OP_ADD, OP_ADD, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        idleCycles(2, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, OP_ADD, OP_SUB, 32'd10, 32'd20, 32'd30, 32'd40, 1'b1, 1'b1, 1'b1);
        idleCycles(3, 1'b1);

        // Randomized traffic with occasional resets and consumer stalls.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 99) < 3),
                          ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 60),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          pickOperand(), pickOperand(), pickOperand(), pickOperand(),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 99) < 70));
        end

        idleCycles(6, 1'b1);
        checkOutput("queue_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
